decodificador: RTL and testbench

DECODIFICADOR -- requirements
Module: decodificador

---
 rtl/decodificador.sv | 56 +++++
 tb/tb_decodificador.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/decodificador.sv
// Three independent BCD-to-seven-segment decoders with registered, active-low outputs.
// Non-BCD codes and reset both show a blank digit.
module decodificador (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] Minutos,
    input  logic [3:0] DezenaSeg,
    input  logic [3:0] Segundos,
    output logic [6:0] OutMinutos,
    output logic [6:0] OutDezena,
    output logic [6:0] OutSegundos
);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [6:0] seg_min_p0;
    logic [6:0] seg_dez_p0;
    logic [6:0] seg_seg_p0;

    // Bit order {a,b,c,d,e,f,g}; a 0 lights the segment.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Stage p0: decoded patterns captured on the clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_min_p0 <= SEG_BLANK;
            seg_dez_p0 <= SEG_BLANK;
            seg_seg_p0 <= SEG_BLANK;
        end else begin
            seg_min_p0 <= bcd_to_seg(Minutos);
            seg_dez_p0 <= bcd_to_seg(DezenaSeg);
            seg_seg_p0 <= bcd_to_seg(Segundos);
        end
    end

    assign OutMinutos  = seg_min_p0;
    assign OutDezena   = seg_dez_p0;
    assign OutSegundos = seg_seg_p0;

endmodule

// File: tb/tb_decodificador.sv
// Scoreboard bench for decodificador: expected patterns are derived from lit-segment
// lists per digit and checked by a monitor one clock edge after each stimulus.
module tb_decodificador;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] Minutos = 4'd5;
    logic [3:0] DezenaSeg = 4'd5;
    logic [3:0] Segundos = 4'd5;
    logic [6:0] OutMinutos;
    logic [6:0] OutDezena;
    logic [6:0] OutSegundos;

    int total = 0;
    int bad = 0;

    logic [20:0] exp_q[$];

    decodificador dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Minutos    (Minutos),
        .DezenaSeg  (DezenaSeg),
        .Segundos   (Segundos),
        .OutMinutos (OutMinutos),
        .OutDezena  (OutDezena),
        .OutSegundos(OutSegundos)
    );

    always #5 clk = ~clk;

    // Which segments are lit for each decimal digit; everything else stays dark.
    function automatic logic [6:0] ref_seg(input int digit);
        string lit[10];
        string s;
        logic [6:0] r;
        lit[0] = "abcdef"; lit[1] = "bc";     lit[2] = "abdeg";   lit[3] = "abcdg";
        lit[4] = "bcfg";   lit[5] = "acdfg";  lit[6] = "acdefg";  lit[7] = "abc";
        lit[8] = "abcdefg"; lit[9] = "abcdfg";
        r = 7'b1111111;
        if (digit >= 0 && digit <= 9) begin
            s = lit[digit];
            for (int i = 0; i < s.len(); i++)
                r[6 - (int'(s.getc(i)) - 97)] = 1'b0;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_expect(input int m, input int d, input int s, input bit blank);
        if (blank) exp_q.push_back({3{7'b1111111}});
        else       exp_q.push_back({ref_seg(m), ref_seg(d), ref_seg(s)});
    endtask

    // Applies inputs just after an edge; the result is due at the following edge.
    task automatic step(input int m, input int d, input int s);
        @(posedge clk);
        #2;
        Minutos = 4'(m); DezenaSeg = 4'(d); Segundos = 4'(s);
        push_expect(m, d, s, 1'b0);
    endtask

    // Monitor: one scoreboard entry is due at each edge that follows a push.
    initial begin
        logic [20:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("OutMinutos",  OutMinutos,  e[20:14]);
                check("OutDezena",   OutDezena,   e[13:7]);
                check("OutSegundos", OutSegundos, e[6:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int m, d, s;
        // Reset with inputs at 5 and the clock running
        #1 rst_n = 1'b0;
        #1;
        check("reset_async_min", OutMinutos,  7'b1111111);
        check("reset_async_dez", OutDezena,   7'b1111111);
        check("reset_async_seg", OutSegundos, 7'b1111111);
        repeat (3) begin
            @(posedge clk);
            #2;
            push_expect(5, 5, 5, 1'b1);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        push_expect(5, 5, 5, 1'b0);

        // Sweep 0..9 on all digits together
        for (int v = 0; v <= 9; v++) step(v, v, v);

        // Independence between digits
        step(1, 2, 3);

        // Non-BCD codes blank the display
        for (int v = 10; v <= 15; v++) step(v, v, v);

        // Mid-cycle input change must wait for the next edge
        step(3, 3, 3);
        @(posedge clk);
        #3;
        Minutos = 4'd8;
        push_expect(8, 3, 3, 1'b0);
        #1;
        check("glitch_hold_min", OutMinutos, ref_seg(3));

        // Mid-run reset while showing 7
        step(7, 7, 7);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset_min", OutMinutos,  7'b1111111);
        check("midreset_dez", OutDezena,   7'b1111111);
        check("midreset_seg", OutSegundos, 7'b1111111);
        @(posedge clk);
        #1;
        check("midreset_hold_min", OutMinutos, 7'b1111111);
        #1;
        rst_n = 1'b1;
        push_expect(7, 7, 7, 1'b0);

        // Randomized digits including non-BCD codes
        repeat (200) begin
            m = int'($urandom_range(0, 15));
            d = int'($urandom_range(0, 15));
            s = int'($urandom_range(0, 15));
            step(m, d, s);
        end

        // Drain the scoreboard within a bounded number of edges
        repeat (3) @(posedge clk);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
